// File: rtl/issue_collect_pkg.sv
// Shared definitions for the issue_collect result-return path.
// Contents:
//   state_t    - collector FSM state encoding
//   ACC_W      - width of an allocator accumulation (signed)
//   DATA_W     - width of an output image word (signed)
//   SAT_MAX/MIN- saturation limits of an output image word
//   saturate() - clamp an ACC_W value into the DATA_W range
package issue_collect_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_SEL  = 3'd2,
        ST_CAP  = 3'd3,
        ST_WR   = 3'd4
    } state_t;

    localparam int ACC_W  = 48;
    localparam int DATA_W = 18;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 48'sd131071;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -48'sd131072;

    function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DATA_W-1:0];
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/collect_quantize.sv
// Combinational quantizer from an accumulation to an output image word.
// Ports:
//   sum        - signed ACC_W accumulation
//   frac_shift - arithmetic right shift amount (0..47)
//   relu_en    - clamp negative shifted values to zero
//   q          - signed DATA_W result, saturated
module collect_quantize
    import issue_collect_pkg::*;
(
    input  logic signed [ACC_W-1:0]  sum,
    input  logic        [5:0]        frac_shift,
    input  logic                     relu_en,
    output logic        [DATA_W-1:0] q
);

    logic signed [ACC_W-1:0] shifted_s;
    logic signed [ACC_W-1:0] clipped_s;

    // Shift with sign fill, optional ReLU, then clamp into the word range.
    always_comb begin
        shifted_s = sum >>> frac_shift;
        if (relu_en && (shifted_s < 48'sd0)) begin
            clipped_s = '0;
        end else begin
            clipped_s = shifted_s;
        end
        q = saturate(clipped_s);
    end

endmodule

// File: rtl/issue_collect.sv
// issue_collect: scans allocators in index order after a positioning round,
// reads each finished sum over the shared result bus, quantizes it and writes
// it to output image memory, acknowledging the allocator.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - pulse to begin a pass (ignored while busy)
//   out_dim, omem_base  - output plane geometry for address generation
//   frac_shift, relu_en - quantizer controls
//   result_valid        - per-allocator "finished sum held" flags
//   result_select       - one-hot bus select (held through SEL and CAP)
//   result_ack          - one-hot single-cycle acknowledge (in WR)
//   result_data/x/y     - shared result bus
//   omem_write_*        - output memory write port
//   busy, done          - pass in progress / pass complete (level)
module issue_collect
    import issue_collect_pkg::*;
#(
    parameter int num_allocators = 220
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                out_dim,
    input  logic [15:0]               omem_base,
    input  logic [5:0]                frac_shift,
    input  logic                      relu_en,
    input  logic [num_allocators-1:0] result_valid,
    output logic [num_allocators-1:0] result_select,
    output logic [num_allocators-1:0] result_ack,
    input  logic [ACC_W-1:0]          result_data,
    input  logic [7:0]                result_x,
    input  logic [7:0]                result_y,
    output logic [15:0]               omem_write_addr,
    output logic [DATA_W-1:0]         omem_write_data,
    output logic                      omem_write_en,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = (num_allocators > 1) ? $clog2(num_allocators) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_allocators - 1);

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic             pass_end_s;
    logic [DATA_W-1:0] quant_s;
    logic [15:0]      product_s;
    logic [15:0]      addr_s;

    function automatic logic [num_allocators-1:0] idx_onehot(input logic [IDX_W-1:0] i);
        logic [num_allocators-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Next-state logic: one cycle per empty index, four per valid index.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        pass_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SCAN;
                    idx_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (result_valid[idx_r]) begin
                    state_s = ST_SEL;
                end else if (idx_r == LAST_IDX) begin
                    state_s    = ST_IDLE;
                    pass_end_s = 1'b1;
                end else begin
                    idx_s = idx_r + IDX_W'(1);
                end
            end
            ST_SEL: begin
                state_s = ST_CAP;
            end
            ST_CAP: begin
                state_s = ST_WR;
            end
            ST_WR: begin
                // Leaving WR behaves like an empty SCAN of the same index.
                if (idx_r == LAST_IDX) begin
                    state_s    = ST_IDLE;
                    pass_end_s = 1'b1;
                end else begin
                    state_s = ST_SCAN;
                    idx_s   = idx_r + IDX_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // State and scan index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    collect_quantize u_quantize (
        .sum        (result_data),
        .frac_shift (frac_shift),
        .relu_en    (relu_en),
        .q          (quant_s)
    );

    // 8x8 row offset plus column, wrapping modulo 2^16.
    assign product_s = {8'h00, result_y} * {8'h00, out_dim};
    assign addr_s    = omem_base + product_s + {8'h00, result_x};

    // Registered outputs, derived from the upcoming state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_select   <= '0;
            result_ack      <= '0;
            omem_write_en   <= 1'b0;
            omem_write_addr <= '0;
            omem_write_data <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            result_select <= ((state_s == ST_SEL) || (state_s == ST_CAP)) ? idx_onehot(idx_s) : '0;
            result_ack    <= (state_s == ST_WR) ? idx_onehot(idx_s) : '0;
            omem_write_en <= (state_s == ST_WR);
            busy          <= (state_s != ST_IDLE);
            // The bus is sampled at the end of CAP; the write presents it in WR.
            if (state_r == ST_CAP) begin
                omem_write_addr <= addr_s;
                omem_write_data <= quant_s;
            end else begin
                omem_write_addr <= omem_write_addr;
                omem_write_data <= omem_write_data;
            end
            if ((state_r == ST_IDLE) && start) begin
                done <= 1'b0;
            end else if (pass_end_s) begin
                done <= 1'b1;
            end else begin
                done <= done;
            end
        end
    end

endmodule

// File: tb/tb_issue_collect.sv
// Self-checking bench for issue_collect with four allocators: directed cases
// with literal expectations, then randomized traffic compared every cycle
// against a per-index cost model of a scan pass.
module tb_issue_collect;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst, start, relu_en;
    logic [7:0]    out_dim;
    logic [15:0]   omem_base;
    logic [5:0]    frac_shift;
    logic [N-1:0]  result_valid, result_select, result_ack;
    logic [47:0]   result_data;
    logic [7:0]    result_x, result_y;
    logic [15:0]   omem_write_addr;
    logic [17:0]   omem_write_data;
    logic          omem_write_en, busy, done;

    logic [47:0]   a_data [N];
    logic [7:0]    a_x [N];
    logic [7:0]    a_y [N];

    always #5 clk = ~clk;

    issue_collect #(.num_allocators(N)) dut (
        .clk(clk), .rst(rst), .start(start), .out_dim(out_dim),
        .omem_base(omem_base), .frac_shift(frac_shift), .relu_en(relu_en),
        .result_valid(result_valid), .result_select(result_select),
        .result_ack(result_ack), .result_data(result_data),
        .result_x(result_x), .result_y(result_y),
        .omem_write_addr(omem_write_addr), .omem_write_data(omem_write_data),
        .omem_write_en(omem_write_en), .busy(busy), .done(done)
    );

    // Allocators: the selected one drives the shared bus, others drive 0.
    always_comb begin
        result_data = '0;
        result_x    = '0;
        result_y    = '0;
        for (int i = 0; i < N; i++) begin
            if (result_select[i]) begin
                result_data = result_data | a_data[i];
                result_x    = result_x | a_x[i];
                result_y    = result_y | a_y[i];
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_start = 0;

    // Model: pass position expressed as (index, cycles spent on that index).
    bit          m_active, m_done, m_hit;
    int          m_idx, m_cnt;
    logic [15:0] m_addr;
    logic [17:0] m_data;

    int          wr_idx_q[$];
    int          wr_cyc_q[$];
    logic [15:0] wr_addr_q[$];
    logic [17:0] wr_data_q[$];
    logic [N-1:0] wr_ack_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [17:0] quant(input logic [47:0] d, input int sh, input bit relu);
        longint s;
        s = longint'($signed(d));
        s = s >>> sh;
        if (relu && s < 0) s = 0;
        if (s > 131071) s = 131071;
        if (s < -131072) s = -131072;
        return s[17:0];
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        int a;
        if (rst) begin
            m_active = 0; m_done = 0; m_hit = 0; m_idx = 0; m_cnt = 0;
            m_addr = '0; m_data = '0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_done = 0; m_idx = 0; m_cnt = 0;
            end
        end else begin
            if (m_cnt == 0) m_hit = result_valid[m_idx];
            if (m_cnt == (m_hit ? 3 : 0)) begin
                m_cnt = 0;
                if (m_idx == N - 1) begin
                    m_active = 0; m_done = 1;
                end else begin
                    m_idx++;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 3) begin
                    a = int'(omem_base) + int'(a_y[m_idx]) * int'(out_dim) + int'(a_x[m_idx]);
                    m_addr = a[15:0];
                    m_data = quant(a_data[m_idx], int'(frac_shift), relu_en);
                end
            end
        end
    endtask

    // One clock: advance the model at the edge, compare just after it.
    task automatic step();
        logic [N-1:0] e_sel;
        bit e_wr;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        e_wr  = m_active && (m_cnt == 3);
        e_sel = (m_active && (m_cnt == 1 || m_cnt == 2)) ? onehot(m_idx) : '0;
        chk("select", 64'(result_select), 64'(e_sel));
        chk("ack", 64'(result_ack), e_wr ? 64'(onehot(m_idx)) : 64'd0);
        chk("write_en", 64'(omem_write_en), 64'(e_wr));
        chk("busy", 64'(busy), 64'(m_active));
        chk("done", 64'(done), 64'(m_done));
        if (e_wr) begin
            chk("write_addr", 64'(omem_write_addr), 64'(m_addr));
            chk("write_data", 64'(omem_write_data), 64'(m_data));
        end
        if (omem_write_en) begin
            for (int i = 0; i < N; i++) if (result_ack[i]) wr_idx_q.push_back(i);
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(omem_write_addr);
            wr_data_q.push_back(omem_write_data);
            wr_ack_q.push_back(result_ack);
        end
        result_valid = result_valid & ~result_ack;
    endtask

    task automatic clear_log();
        wr_idx_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete();
        wr_data_q.delete(); wr_ack_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        lat = cyc - t_start;
    endtask

    task automatic one_quant(input string name, input logic [47:0] d, input int sh,
                             input bit relu, input logic [17:0] exp);
        int lat;
        clear_log();
        a_data[0] = d; a_x[0] = 8'd1; a_y[0] = 8'd1;
        frac_shift = 6'(sh); relu_en = relu;
        result_valid = 4'b0001;
        pulse_start();
        wait_done(lat);
        chk({name, "_count"}, 64'(wr_data_q.size()), 64'd1);
        if (wr_data_q.size() > 0) chk(name, 64'(wr_data_q[0]), 64'(exp));
    endtask

    task automatic rand_alloc(input int i);
        logic [63:0] r64;
        logic signed [47:0] t;
        r64 = {$urandom(), $urandom()};
        t = r64[47:0];
        t = t >>> $urandom_range(0, 47);
        a_data[i] = t;
        a_x[i] = 8'($urandom());
        a_y[i] = 8'($urandom());
    endtask

    initial begin
        int lat;
        logic [47:0] v;
        rst = 1'b1; start = 1'b0; relu_en = 1'b0; out_dim = 8'd13;
        omem_base = 16'd100; frac_shift = 6'd0; result_valid = '0;
        for (int i = 0; i < N; i++) begin a_data[i] = '0; a_x[i] = '0; a_y[i] = '0; end
        m_active = 0; m_done = 0; m_hit = 0; m_idx = 0; m_cnt = 0; m_addr = '0; m_data = '0;
        #2;
        step(); step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_addr", 64'(omem_write_addr), 64'd0);
        chk("reset_data", 64'(omem_write_data), 64'd0);
        rst = 1'b0;
        step();

        // No valid allocators: four empty scans.
        clear_log();
        pulse_start();
        wait_done(lat);
        chk("empty_latency", 64'(lat), 64'd4);
        chk("empty_writes", 64'(wr_cyc_q.size()), 64'd0);

        // Only allocator 2 valid.
        clear_log();
        a_data[2] = 48'd1000; a_x[2] = 8'd3; a_y[2] = 8'd5;
        out_dim = 8'd13; omem_base = 16'd100; frac_shift = 6'd0; relu_en = 1'b0;
        result_valid = 4'b0100;
        pulse_start();
        wait_done(lat);
        chk("single_latency", 64'(lat), 64'd7);
        chk("single_count", 64'(wr_cyc_q.size()), 64'd1);
        if (wr_cyc_q.size() > 0) begin
            chk("single_addr", 64'(wr_addr_q[0]), 64'd168);
            chk("single_data", 64'(wr_data_q[0]), 64'd1000);
            chk("single_ack", 64'(wr_ack_q[0]), 64'b0100);
            chk("single_wr_cycle", 64'(wr_cyc_q[0] - t_start), 64'd5);
        end

        // Quantizer corners.
        v = -48'sd1073741824;
        one_quant("q_neg_sat", v, 4, 1'b0, 18'h20000);
        one_quant("q_relu", v, 4, 1'b1, 18'h00000);
        v = 48'h3FFFF0;
        one_quant("q_pos_sat", v, 4, 1'b0, 18'h1FFFF);
        v = 48'h12340;
        one_quant("q_plain", v, 4, 1'b0, 18'd4660);

        // All valid, with a stray start in the middle of the pass.
        clear_log();
        frac_shift = 6'd2;
        for (int i = 0; i < N; i++) rand_alloc(i);
        result_valid = 4'b1111;
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat);
        chk("all_latency", 64'(lat), 64'd16);
        chk("all_count", 64'(wr_idx_q.size()), 64'd4);
        for (int i = 0; i < wr_idx_q.size() && i < N; i++) begin
            chk("all_order", 64'(wr_idx_q[i]), 64'(i));
            chk("all_spacing", 64'(wr_cyc_q[i] - t_start), 64'(4 * i + 3));
        end
        step();
        chk("all_idle_after", 64'(busy), 64'd0);

        // Reset while index 1 is in CAP.
        clear_log();
        result_valid = 4'b1111;
        pulse_start();
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_select", 64'(result_select), 64'd0);
        chk("rst_ack", 64'(result_ack), 64'd0);
        chk("rst_we", 64'(omem_write_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(omem_write_addr), 64'd0);
        chk("rst_data", 64'(omem_write_data), 64'd0);
        chk("rst_writes", 64'(wr_idx_q.size()), 64'd1);
        step();
        chk("rst_no_late_write", 64'(wr_idx_q.size()), 64'd1);
        clear_log();
        result_valid[0] = 1'b1;
        pulse_start();
        wait_done(lat);
        chk("rescan_count", 64'(wr_idx_q.size()), 64'd4);
        if (wr_idx_q.size() > 0) chk("rescan_first", 64'(wr_idx_q[0]), 64'd0);
        chk("rescan_latency", 64'(lat), 64'd16);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 399) == 0);
            frac_shift = 6'($urandom_range(0, 47));
            relu_en = 1'($urandom());
            out_dim = 8'($urandom());
            omem_base = 16'($urandom());
            for (int i = 0; i < N; i++) begin
                if (!result_valid[i] && $urandom_range(0, 5) == 0) begin
                    rand_alloc(i);
                    result_valid[i] = 1'b1;
                end
            end
            step();
        end
        start = 1'b0;
        rst = 1'b0;
        begin
            int n = 0;
            while (busy && n < 200) begin
                step();
                n++;
            end
            chk("final_idle", 64'(busy), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
